// File: rtl/ckgate_ctrl.sv
// Enable controller for a CKGATE cell: turns module activity into a glitch-free
// enable with idle hysteresis, a fixed wake-up delay and an ACK handshake.
// Also keeps a saturating count of cycles spent with the clock gated off.
module ckgate_ctrl #(
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              REQ,
  input  logic              BUSY,
  input  logic              FORCE_ON,
  input  logic              TE_IN,
  input  logic [IDLE_W-1:0] IDLE_THR,
  input  logic              CNT_CLR,
  output logic              E,
  output logic              TE,
  output logic              ACK,
  output logic [1:0]        STATE,
  output logic [CNT_W-1:0]  GATED_CNT
);

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StWake = 2'd1,
    StOn   = 2'd2,
    StIdle = 2'd3
  } state_e;

  // Last wake-counter value seen in WAKE before ACK is granted.
  localparam logic [3:0]       WakeLast = 4'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e             state_q, state_d;
  logic [3:0]         wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]   gated_cnt_q, gated_cnt_d;
  logic               e_q, e_d;
  logic               ack_q, ack_d;
  logic               act;

  assign act = REQ | BUSY | FORCE_ON;

  // Next-state logic for the gating FSM and its wake/idle counters.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      StOff: begin
        if (act) begin
          state_d    = StWake;
          wake_cnt_d = '0;
        end
      end
      StWake: begin
        // Wake always runs to completion, regardless of act.
        wake_cnt_d = wake_cnt_q + 4'd1;
        if (wake_cnt_q == WakeLast) begin
          state_d = StOn;
        end
      end
      StOn: begin
        if (!act) begin
          if (IDLE_THR == '0) begin
            state_d = StOff;
          end else begin
            state_d    = StIdle;
            idle_cnt_d = IDLE_THR - IDLE_W'(1);
          end
        end
      end
      StIdle: begin
        // act takes priority over the counter expiring.
        if (act) begin
          state_d = StOn;
        end else if (idle_cnt_q == '0) begin
          state_d = StOff;
        end else begin
          idle_cnt_d = idle_cnt_q - IDLE_W'(1);
        end
      end
    endcase
  end

  // E/ACK are decoded from the next state so the outputs come straight from flops.
  always_comb begin
    e_d   = (state_d != StOff);
    ack_d = (state_d == StOn) || (state_d == StIdle);
  end

  // Gated-cycle statistics: clear wins over increment, saturates at all-ones.
  always_comb begin
    gated_cnt_d = gated_cnt_q;
    if (CNT_CLR) begin
      gated_cnt_d = '0;
    end else if ((state_q == StOff) && (gated_cnt_q != CntMax)) begin
      gated_cnt_d = gated_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q     <= StOff;
      wake_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      gated_cnt_q <= '0;
      e_q         <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      gated_cnt_q <= gated_cnt_d;
      e_q         <= e_d;
      ack_q       <= ack_d;
    end
  end

  assign E         = e_q;
  assign ACK       = ack_q;
  assign TE        = TE_IN;
  assign STATE     = state_q;
  assign GATED_CNT = gated_cnt_q;

endmodule

// File: tb/tb_ckgate_ctrl.sv
// Self-checking bench for ckgate_ctrl: a behavioural model predicts each cycle's
// outputs into a scoreboard queue, which is popped and compared after the edge.
module tb_ckgate_ctrl;

  localparam int unsigned IdleW   = 8;
  localparam int unsigned WakeCyc = 2;
  localparam int unsigned CntW    = 4;

  logic             ck;
  logic             rn;
  logic             req;
  logic             busy;
  logic             force_on;
  logic             te_in;
  logic [IdleW-1:0] idle_thr;
  logic             cnt_clr;
  logic             e;
  logic             te;
  logic             ack;
  logic [1:0]       state;
  logic [CntW-1:0]  gated_cnt;

  ckgate_ctrl #(
    .IDLE_W  (IdleW),
    .WAKE_CYC(WakeCyc),
    .CNT_W   (CntW)
  ) dut (
    .CK       (ck),
    .RN       (rn),
    .REQ      (req),
    .BUSY     (busy),
    .FORCE_ON (force_on),
    .TE_IN    (te_in),
    .IDLE_THR (idle_thr),
    .CNT_CLR  (cnt_clr),
    .E        (e),
    .TE       (te),
    .ACK      (ack),
    .STATE    (state),
    .GATED_CNT(gated_cnt)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int st;
    int e;
    int ack;
    int cnt;
  } exp_t;

  exp_t sb[$];

  int n_vec;
  int n_err;
  logic te_tog;

  // Reference model: wake/idle tracked as "cycles remaining" in the state.
  int m_state;
  int m_wake_left;
  int m_idle_left;
  int m_cnt;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit a, input int thr, input bit clr, input bit r);
    if (!r) begin
      m_state     = 0;
      m_wake_left = 0;
      m_idle_left = 0;
      m_cnt       = 0;
    end else begin
      if (clr) m_cnt = 0;
      else if (m_state == 0 && m_cnt < (1 << CntW) - 1) m_cnt = m_cnt + 1;
      case (m_state)
        0: if (a) begin
          m_state     = 1;
          m_wake_left = WakeCyc;
        end
        1: begin
          m_wake_left = m_wake_left - 1;
          if (m_wake_left == 0) m_state = 2;
        end
        2: if (!a) begin
          if (thr == 0) m_state = 0;
          else begin
            m_state     = 3;
            m_idle_left = thr;
          end
        end
        default: begin
          if (a) m_state = 2;
          else begin
            m_idle_left = m_idle_left - 1;
            if (m_idle_left == 0) m_state = 0;
          end
        end
      endcase
    end
  endtask

  // One clock cycle: drive, check TE, predict, clock, pop and compare.
  task automatic cyc(input bit rq, input bit bs, input bit fo, input int thr,
                     input bit clr, input bit r);
    exp_t x;
    bit   tev;
    tev      = te_tog;
    te_tog   = ~te_tog;
    req      = rq;
    busy     = bs;
    force_on = fo;
    idle_thr = IdleW'(thr);
    cnt_clr  = clr;
    rn       = r;
    te_in    = tev;
    #1;
    check_val("te", int'(te), int'(tev));
    model_step(rq | bs | fo, thr, clr, r);
    x.st  = m_state;
    x.e   = (m_state != 0) ? 1 : 0;
    x.ack = (m_state >= 2) ? 1 : 0;
    x.cnt = m_cnt;
    sb.push_back(x);
    @(posedge ck);
    #1;
    x = sb.pop_front();
    check_val("state", int'(state), x.st);
    check_val("e", int'(e), x.e);
    check_val("ack", int'(ack), x.ack);
    check_val("gated_cnt", int'(gated_cnt), x.cnt);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    te_tog   = 1'b0;
    rn       = 1'b0;
    req      = 1'b0;
    busy     = 1'b0;
    force_on = 1'b0;
    te_in    = 1'b0;
    idle_thr = '0;
    cnt_clr  = 1'b0;
    m_state  = 0;
    m_cnt    = 0;

    // Reset.
    repeat (2) cyc(0, 0, 0, 4, 0, 0);
    // Wake-up: OFF -> WAKE -> WAKE -> ON.
    repeat (5) cyc(1, 0, 0, 4, 0, 1);
    // Idle hysteresis of 4 cycles, then gated off for a few cycles.
    repeat (8) cyc(0, 0, 0, 4, 0, 1);
    // Back on via FORCE_ON, then BUSY rescues IDLE exactly as the counter expires.
    repeat (4) cyc(0, 0, 1, 2, 0, 1);
    repeat (2) cyc(0, 0, 0, 2, 0, 1);
    repeat (3) cyc(0, 1, 0, 2, 0, 1);
    // Threshold changes while in IDLE are ignored.
    cyc(0, 0, 0, 3, 0, 1);
    repeat (5) cyc(0, 0, 0, 9, 0, 1);
    // Zero threshold: straight to OFF; one-cycle REQ pulse runs a full wake.
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 1);
    // Saturation, then clear with a pending increment.
    repeat (20) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    // Reset while ON.
    repeat (4) cyc(1, 0, 0, 3, 0, 1);
    cyc(1, 0, 0, 3, 0, 0);
    repeat (2) cyc(0, 0, 0, 3, 0, 1);
    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 9) == 0), int'($urandom_range(0, 5)),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ckgate_ctrl.md
Name: ckgate_ctrl

Overview:
- Enable controller for the CKGATE clock-gate cell. Generates the E and TE inputs of the cell from module activity (REQ/BUSY) using idle-hysteresis, a wake-up delay and an acknowledge handshake.
- Runs on the free-running (ungated) clock CK.
- Sits beside each CKGATE instance.
- Exposes a saturating gated-cycle counter for power statistics.

Parameters:
- IDLE_W, 8, width of the idle-threshold input and the idle down-counter.
- WAKE_CYC, 2, cycles between E rising and ACK asserting. Legal range 1..15.
- CNT_W, 16, width of the gated-cycle statistics counter.

Ports:
- CK  input  1  free-running clock; all state updates on rising edge.
- RN  input  1  reset, synchronous, active-low.
- REQ  input  1  requester needs the gated clock.
- BUSY  input  1  gated logic still has work in flight; holds the clock on.
- FORCE_ON  input  1  software override; clock never gated while high.
- TE_IN  input  1  scan/test enable from DFT.
- IDLE_THR  input  IDLE_W  idle cycles required before gating; sampled on entry to IDLE.
- CNT_CLR  input  1  synchronous clear of GATED_CNT.
- E  output  1  registered enable to CKGATE.E.
- TE  output  1  to CKGATE.TE; combinational copy of TE_IN.
- ACK  output  1  registered; gated clock is guaranteed running.
- STATE  output  2  current FSM state: OFF=0, WAKE=1, ON=2, IDLE=3.
- GATED_CNT  output  CNT_W  number of CK cycles spent in OFF; saturating.

Behaviour:
- Reset (RN=0 at a rising CK edge), from any state:
  - STATE=OFF, E=0, ACK=0.
  - Wake counter=0, idle counter=0, GATED_CNT=0.
  - Reset overrides all other inputs.
- TE = TE_IN at all times, including during reset. TE_IN has no effect on the FSM, E, ACK or GATED_CNT.
- Definitions:
  - act = REQ | BUSY | FORCE_ON.
  - E = 1 in WAKE, ON and IDLE; E = 0 in OFF.
  - ACK = 1 in ON and IDLE only.
  - E and ACK are registered and change only at CK rising edges, so E is glitch-free relative to CKGATE.
- OFF:
  - If act, go to WAKE and clear the wake counter.
  - Otherwise stay in OFF.
- WAKE:
  - Wake counter increments every cycle. When it reaches WAKE_CYC, go to ON.
  - WAKE always completes once entered, even if act drops. ACK is never withdrawn mid-wake because it was never given.
  - Timing: REQ sampled high in OFF at edge n gives E=1 after edge n, and ACK=1 after edge n+WAKE_CYC.
- ON:
  - If act, stay in ON.
  - If !act and IDLE_THR==0, go directly to OFF; E and ACK fall together on the next edge.
  - If !act and IDLE_THR!=0, go to IDLE and load the idle counter with IDLE_THR-1.
- IDLE:
  - If act, return to ON. ACK stays 1 and E stays 1, with no gap.
  - Else if idle counter==0, go to OFF.
  - Else decrement the idle counter.
  - Net effect: with act low throughout, STATE holds IDLE for exactly IDLE_THR cycles before OFF.
  - Changes to IDLE_THR while in IDLE are ignored until the next entry.
- Simultaneous events:
  - act rising in the same cycle the idle counter hits 0: act wins, go to ON.
  - FORCE_ON behaves identically to REQ for state transitions.
- GATED_CNT:
  - Each edge with STATE==OFF (after reset), increments by 1. Saturates at 2^CNT_W-1 and does not wrap.
  - CNT_CLR=1 sets it to 0; clear has priority over increment in the same cycle.
  - The increment uses the current-state value, so the cycle that leaves OFF still counts.
- Reset mid-operation: the next edge forces OFF, and E drops immediately on that edge even if ACK was high. Requesters must treat RN low as clock-lost.
- No illegal states: the 2-bit encoding is fully used.

Test Plan:
- Reset, then REQ=1 at cycle 0, WAKE_CYC=2 -> STATE 0→1→1→2. E=1 from cycle 1. ACK=1 from cycle 3. GATED_CNT=1.
- In ON, IDLE_THR=4, drop REQ/BUSY/FORCE_ON -> IDLE for exactly 4 cycles, then OFF. E and ACK fall together. GATED_CNT then increments once per cycle.
- In IDLE with counter=0, raise BUSY the same cycle -> next STATE=ON. E and ACK never deassert. GATED_CNT unchanged.
- IDLE_THR=0, drop REQ in ON -> OFF on the next edge, no IDLE cycle. Pulse REQ for 1 cycle from OFF -> WAKE runs a full 2 cycles, ON for 1 cycle, then OFF.
- CNT_W=4: hold OFF for 20 cycles -> GATED_CNT saturates at 15. Assert CNT_CLR together with an increment -> GATED_CNT=0 next cycle.
- Toggle TE_IN in every state -> TE follows same-cycle; STATE, E and ACK unaffected. Assert RN=0 while in ON -> next edge STATE=0, E=0, ACK=0, GATED_CNT=0, with TE still following TE_IN.
